// File: rtl/uart_tx_model.sv
// Simulation-side UART transmitter: bytes pushed over valid/ready are buffered in a
// FIFO and serialized as start / data (LSB first) / stop bits at CLK_HZ/BIT_RATE clocks per bit.
module uart_tx_model #(
  parameter int BIT_RATE     = 9600,
  parameter int CLK_HZ       = 50_000_000,
  parameter int PAYLOAD_BITS = 8,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          uart_tx_en,
  input  logic                          tx_data_valid,
  input  logic [PAYLOAD_BITS-1:0]       tx_data,
  output logic                          tx_data_ready,
  output logic                          uart_txd,
  output logic                          uart_tx_busy,
  output logic                          uart_tx_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int CPB = CLK_HZ / BIT_RATE;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = (CPB > 2) ? $clog2(CPB) : 1;
  localparam int IW  = 4;

  if (CPB < 2) begin : g_bad_cpb
    $error("uart_tx_model: CLK_HZ/BIT_RATE must be at least 2");
  end
  if (PAYLOAD_BITS < 5 || PAYLOAD_BITS > 8) begin : g_bad_payload
    $error("uart_tx_model: PAYLOAD_BITS must be 5..8");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_tx_model: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_model: FIFO_DEPTH must be a power of two, at least 2");
  end

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [PAYLOAD_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [AW:0]             level_q, level_d;
  logic                    full, empty, push, pop;

  state_t                  state_q;
  logic [CW-1:0]           cnt_q;
  logic [IW-1:0]           idx_q;
  logic [PAYLOAD_BITS-1:0] shift_q;
  logic                    txd_q, busy_q, done_q;
  logic                    bit_last, stop_last;

  assign full          = (level_q == (AW+1)'(FIFO_DEPTH));
  assign empty         = (level_q == '0);
  assign tx_data_ready = !full && !reset;
  assign push          = tx_data_valid && tx_data_ready;

  assign bit_last  = (cnt_q == CW'(CPB - 1));
  assign stop_last = (state_q == STOP) && bit_last && (idx_q == IW'(STOP_BITS - 1));
  // A pop is only legal at the two frame-start points; the FSM below relies on this exact signal.
  assign pop = !reset && !empty && uart_tx_en && ((state_q == IDLE) || stop_last);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= tx_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          txd_q <= 1'b1;
          if (pop) begin
            shift_q <= mem_q[rd_ptr_q];
            state_q <= START;
            txd_q   <= 1'b0;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
            idx_q   <= '0;
          end
        end
        START: begin
          if (bit_last) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            state_q <= DATA;
            txd_q   <= shift_q[0];
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DATA: begin
          if (bit_last) begin
            cnt_q <= '0;
            if (idx_q == IW'(PAYLOAD_BITS - 1)) begin
              idx_q   <= '0;
              state_q <= STOP;
              txd_q   <= 1'b1;
            end else begin
              idx_q   <= idx_q + 1'b1;
              shift_q <= shift_q >> 1;
              txd_q   <= shift_q[1];
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        STOP: begin
          if (bit_last) begin
            cnt_q <= '0;
            if (idx_q == IW'(STOP_BITS - 1)) begin
              idx_q  <= '0;
              done_q <= 1'b1;
              // Chain straight into the next start bit so the line never idles between queued bytes.
              if (pop) begin
                shift_q <= mem_q[rd_ptr_q];
                state_q <= START;
                txd_q   <= 1'b0;
              end else begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
                txd_q   <= 1'b1;
              end
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          txd_q   <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign uart_txd     = txd_q;
  assign uart_tx_busy = busy_q;
  assign uart_tx_done = done_q;
  assign fifo_level   = level_q;

endmodule

// File: doc/uart_tx_model.md
# uart_tx_model

Testbench UART transmitter that accepts bytes from a simulation-side producer through a valid/ready push interface and buffers them in an internal FIFO. It serializes them onto a single line as start, data (LSB first) and stop bits at a fixed bit rate. It drives the DUT's UART receive pin in co-simulation, so DUT firmware can be fed console input. It pairs with the testbench UART receiver that logs DUT output.

## Interface
- `BIT_RATE`, 9600: line bit rate in bits/s.
- `CLK_HZ`, 50_000_000: `clk` frequency in Hz.
- `PAYLOAD_BITS`, 8: data bits per frame, 5..8.
- `STOP_BITS`, 1: stop bits per frame, 1 or 2.
- `FIFO_DEPTH`, 16: entries in the byte FIFO; power of two, at least 2.
- Derived: `CPB` = `CLK_HZ/BIT_RATE`, using truncating integer division; `CPB` must be at least 2, enforced by an elaboration-time check.
- `clk` in 1: sole clock; all logic is on the rising edge.
- `reset` in 1: reset; synchronous, active-high.
- `uart_tx_en` in 1: enables starting new frames; sampled only in IDLE and at the last cycle of STOP.
- `tx_data_valid` in 1: producer has a byte.
- `tx_data` in `PAYLOAD_BITS`: byte to enqueue.
- `tx_data_ready` out 1: FIFO can accept; combinational `!full && !reset`.
- `uart_txd` out 1: serial line, registered, idles high.
- `uart_tx_busy` out 1: high whenever state is not IDLE.
- `uart_tx_done` out 1: one-cycle pulse at frame completion.
- `fifo_level` out `$clog2(FIFO_DEPTH)+1`: current FIFO occupancy.

## Operation
- Push: a byte is written when `tx_data_valid && tx_data_ready`. It is ignored otherwise, with no error flag.
- FIFO pointers have wrap-around; `fifo_level` counts 0..`FIFO_DEPTH`.
  - Full means level == `FIFO_DEPTH`; empty means level == 0.
  - A push and a pop in the same cycle leave the level unchanged.
  - When full, `tx_data_ready` = 0 even if a pop occurs that cycle.
- FSM states: IDLE, START, DATA, STOP. One bit counter (0..`CPB`-1) and one bit index.
- IDLE: `uart_txd`=1. If the FIFO is not empty and `uart_tx_en`=1, pop the head into the shift register and enter START.
- START: `uart_txd`=0 for `CPB` cycles, then go to DATA with index 0.
- DATA: `uart_txd` = shift[0] for `CPB` cycles per bit, then shift right. After `PAYLOAD_BITS` bits, go to STOP.
- STOP: `uart_txd`=1 for `STOP_BITS`*`CPB` cycles. On the last cycle:
  - If the FIFO is not empty and `uart_tx_en`=1, pop and go directly to START, with no idle gap.
  - Otherwise go to IDLE.
- `uart_tx_done` pulses for the one cycle after the last STOP cycle, whether the next state is IDLE or START.
- Frame length is exactly (1+`PAYLOAD_BITS`+`STOP_BITS`)*`CPB` cycles.
- `uart_tx_en` deasserted mid-frame: the current frame completes normally and no further frame starts. Queued bytes remain in the FIFO.
- Reset, including mid-frame, takes effect at the next edge:
  - state IDLE, FIFO flushed, `fifo_level`=0;
  - `uart_txd`=1, `uart_tx_busy`=0, `uart_tx_done`=0;
  - counters 0.
- A push in the same cycle as reset is dropped.

## Timing
- Reset values: `uart_txd`=1, `uart_tx_busy`=0, `uart_tx_done`=0, `fifo_level`=0. `tx_data_ready`=0 while `reset` is high and 1 in the first cycle after.
- Latency: with the FSM in IDLE, FIFO empty and `uart_tx_en`=1, a byte pushed at edge E0 is visible as nonempty after E0. At E1, `uart_txd` falls, `uart_tx_busy` rises and `fifo_level` returns to 0.
- Each bit cell is exactly `CPB` clocks, with no fractional correction.
- `uart_tx_busy` falls in the same cycle `uart_tx_done` pulses, unless back-to-back chaining keeps it high.
- `fifo_level` updates one edge after the push or pop.

## Test plan
- **Single frame:** `CLK_HZ`=1_000_000, `BIT_RATE`=100_000 (`CPB`=10); push 0x55 with en=1. Required response:
  - `uart_txd` shows 0 then 1,0,1,0,1,0,1,0, then 1, each held 10 cycles;
  - 100 cycles from fall to `uart_tx_done`;
  - exactly one done pulse.
- **Back-to-back:** push 0x00, 0xFF, 0xA5, 0x0F consecutively. Required response:
  - a continuous 400-cycle busy window with no gap between stop and start;
  - 4 done pulses, each 100 cycles apart.
- **Full FIFO:** en=0; push 17 bytes into `FIFO_DEPTH`=16. Required response:
  - `tx_data_ready`=0 after the 16th push; byte 17 is dropped; `fifo_level`=16;
  - after raising en, exactly 16 frames are sent, in push order.
- **Enable gating:** drop en at cycle 30 of the first of 3 queued frames. Required response:
  - that frame completes at cycle 100;
  - `fifo_level` stays 2 and `uart_txd` stays 1 until en returns.
- **Reset mid-frame:** assert reset at cycle 45 of a frame with 3 bytes queued. Required response:
  - next cycle `uart_txd`=1, busy=0, `fifo_level`=0;
  - no done pulse, and no further activity.
- **Loopback:** connect `uart_txd` to the testbench UART receiver with matching parameters; send "Hi\n". Required response: the receiver logs the line "Hi\n".
